// File: rtl/data_sram_responder.sv
// Data-side memory responder: word RAM with byte-lane writes, registered read
// data, an out-of-range flag and optional wait states that request a pipeline stall.
module data_sram_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        addr_err
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic          acc_fire;
  logic [3:0]    acc_wen;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          unused_addr_bits;

  // Range check uses the full word address so aliased high addresses are rejected.
  assign in_range         = {2'b00, acc_addr[31:2]} < 32'(DEPTH);
  assign idx              = acc_addr[AW+1:2];
  assign unused_addr_bits = ^acc_addr[1:0];

  generate
    if (WAIT_CYCLES == 0) begin : g_nowait
      assign acc_fire  = data_sram_en;
      assign acc_wen   = data_sram_wen;
      assign acc_addr  = data_sram_addr;
      assign acc_wdata = data_sram_wdata;
      assign stallreq  = 1'b0;
    end else begin : g_wait
      typedef enum logic {S_IDLE, S_WAIT} state_t;
      state_t      state;
      logic [3:0]  cnt;
      logic [3:0]  req_wen;
      logic [31:0] req_addr;
      logic [31:0] req_wdata;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state     <= S_IDLE;
          cnt       <= '0;
          req_wen   <= '0;
          req_addr  <= '0;
          req_wdata <= '0;
        end else begin
          case (state)
            S_IDLE: if (data_sram_en) begin
              req_wen   <= data_sram_wen;
              req_addr  <= data_sram_addr;
              req_wdata <= data_sram_wdata;
              cnt       <= 4'(WAIT_CYCLES - 1);
              state     <= S_WAIT;
            end
            S_WAIT: begin
              if (cnt != '0) cnt <= cnt - 1'b1;
              else           state <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end

      // The request cycle itself counts as the first stall cycle, hence N-1 in cnt.
      assign stallreq  = (state == S_IDLE) ? data_sram_en : (cnt != '0);
      assign acc_fire  = (state == S_WAIT) && (cnt == '0);
      assign acc_wen   = req_wen;
      assign acc_addr  = req_addr;
      assign acc_wdata = req_wdata;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (acc_fire && in_range && !rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_wen[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sram_rdata <= '0;
      addr_err        <= 1'b0;
    end else if (acc_fire) begin
      if (!in_range) begin
        data_sram_rdata <= '0;
        addr_err        <= 1'b1;
      end else begin
        addr_err <= 1'b0;
        if (acc_wen == '0) data_sram_rdata <= mem[idx];
      end
    end
  end
endmodule
